// File: rtl/ruta_datos_bus.sv
// Shared-bus datapath (A, B, C, T, AC) with an add/sub ALU, driven directly by control-unit strobes.
// Optional ALU_SAT_EN: saturating add/subtract instead of wrap-around; carry still reports overflow/borrow.
module ruta_datos_bus #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W-1:0] c_in,
    input  logic              Wa,
    input  logic              Wb,
    input  logic              Wc,
    input  logic              Wt,
    input  logic              Wac,
    input  logic              Ra,
    input  logic              Rb,
    input  logic              Rc,
    input  logic              Rac,
    input  logic              S,
    input  logic              R,
    input  logic              fin,
    output logic [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [DATA_W-1:0] c_out,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              carry,
    output logic              bus_err
);
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, t_q, t_d, ac_q, ac_d, res_q, res_d;
    logic              done_q, done_d, carry_q, carry_d, err_q, err_d;
    logic [2:0]        rd_cnt;
    logic              multi_rd;
    logic [DATA_W:0]   add_full, sub_full;
    logic [DATA_W-1:0] add_res, sub_res;

    assign rd_cnt   = {2'b0, Ra} + {2'b0, Rb} + {2'b0, Rc} + {2'b0, Rac};
    assign multi_rd = (rd_cnt > 3'd1);

    always_comb begin
        bus = '0;
        if (rd_cnt == 3'd1) begin
            if (Ra)       bus = a_q;
            else if (Rb)  bus = b_q;
            else if (Rc)  bus = c_q;
            else          bus = ac_q;
        end
    end

    // MSB of the widened result is the carry-out (add) or borrow (sub).
    assign add_full = {1'b0, t_q} + {1'b0, bus};
    assign sub_full = {1'b0, t_q} - {1'b0, bus};

`ifdef ALU_SAT_EN
    assign add_res = add_full[DATA_W] ? '1 : add_full[DATA_W-1:0];
    assign sub_res = sub_full[DATA_W] ? '0 : sub_full[DATA_W-1:0];
`else
    assign add_res = add_full[DATA_W-1:0];
    assign sub_res = sub_full[DATA_W-1:0];
`endif

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        t_d     = t_q;
        ac_d    = ac_q;
        res_d   = res_q;
        carry_d = carry_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (load) begin
            a_d     = a_in;
            b_d     = b_in;
            c_d     = c_in;
            t_d     = '0;
            ac_d    = '0;
            carry_d = 1'b0;
            err_d   = 1'b0;
        end else begin
            if (fin) begin
                res_d  = c_q;
                done_d = 1'b1;
            end
            // A contended bus carries no valid data, so nothing is written from it.
            if (!multi_rd) begin
                if (Wa) a_d = bus;
                if (Wb) b_d = bus;
                if (Wc) c_d = bus;
                if (Wt) t_d = bus;
                if (Wac) begin
                    if (S && !R) begin
                        ac_d    = add_res;
                        carry_d = add_full[DATA_W];
                    end else if (R && !S) begin
                        ac_d    = sub_res;
                        carry_d = sub_full[DATA_W];
                    end else if (!S && !R) begin
                        ac_d    = bus;
                    end
                end
            end
            err_d = err_q | multi_rd | (Wac & S & R);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            t_q     <= '0;
            ac_q    <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            t_q     <= t_d;
            ac_q    <= ac_d;
            res_q   <= res_d;
            done_q  <= done_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign a_out   = a_q;
    assign b_out   = b_q;
    assign c_out   = c_q;
    assign result  = res_q;
    assign done    = done_q;
    assign carry   = carry_q;
    assign bus_err = err_q;
endmodule

// File: tb/tb_ruta_datos_bus.sv
// Directed bench for ruta_datos_bus: expectations queued as stimulus is applied, popped and checked on sampling.
module tb_ruta_datos_bus;
    localparam int DATA_W = 8;
`ifdef ALU_SAT_EN
    localparam logic [7:0] ADD_OV = 8'd255;
    localparam logic [7:0] SUB_UN = 8'd0;
`else
    localparam logic [7:0] ADD_OV = 8'd44;
    localparam logic [7:0] SUB_UN = 8'd254;
`endif

    logic clk, reset, load, fin;
    logic [DATA_W-1:0] a_in, b_in, c_in;
    logic Wa, Wb, Wc, Wt, Wac, Ra, Rb, Rc, Rac, S, R;
    logic [DATA_W-1:0] bus, a_out, b_out, c_out, result;
    logic done, carry, bus_err;

    ruta_datos_bus #(.DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .load(load),
        .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .Wa(Wa), .Wb(Wb), .Wc(Wc), .Wt(Wt), .Wac(Wac),
        .Ra(Ra), .Rb(Rb), .Rc(Rc), .Rac(Rac),
        .S(S), .R(R), .fin(fin),
        .bus(bus), .a_out(a_out), .b_out(b_out), .c_out(c_out),
        .result(result), .done(done), .carry(carry), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {K_BUS, K_A, K_B, K_C, K_RES, K_DONE, K_CARRY, K_ERR} kind_t;
    typedef struct {
        kind_t      kind;
        logic [7:0] exp;
        string      tag;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [7:0] obs(kind_t k);
        case (k)
            K_BUS:   return bus;
            K_A:     return a_out;
            K_B:     return b_out;
            K_C:     return c_out;
            K_RES:   return result;
            K_DONE:  return {7'b0, done};
            K_CARRY: return {7'b0, carry};
            default: return {7'b0, bus_err};
        endcase
    endfunction

    task automatic expect_v(kind_t k, logic [7:0] e, string t);
        q.push_back('{kind: k, exp: e, tag: t});
    endtask

    task automatic drain();
        exp_t it;
        logic [7:0] o;
        while (q.size() > 0) begin
            it = q.pop_front();
            o  = obs(it.kind);
            checks++;
            assert (o === it.exp)
            else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", it.tag, o, it.exp);
            end
        end
    endtask

    task automatic clr();
        {Wa, Wb, Wc, Wt, Wac, Ra, Rb, Rc, Rac, S, R, fin, load} = '0;
    endtask

    // Advance one edge; inputs are held for exactly that one cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        clr();
        reset = 1'b0;
    endtask

    task automatic load_regs(logic [7:0] a, logic [7:0] b, logic [7:0] c);
        a_in = a; b_in = b; c_in = c; load = 1'b1;
        tick();
    endtask

    // AC is only observable through the bus.
    task automatic check_ac(logic [7:0] e, string t);
        Rac = 1'b1;
        #1;
        expect_v(K_BUS, e, t);
        drain();
        Rac = 1'b0;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        a_in = '0; b_in = '0; c_in = '0;
        tick();
        expect_v(K_A, 0, "rst_a"); expect_v(K_RES, 0, "rst_res");
        expect_v(K_DONE, 0, "rst_done"); expect_v(K_ERR, 0, "rst_err");
        drain();
        check_ac(0, "rst_ac");

        // A+A into C, then fin.
        load_regs(3, 5, 0);
        expect_v(K_A, 3, "ld_a"); expect_v(K_B, 5, "ld_b"); expect_v(K_C, 0, "ld_c");
        drain();
        Ra = 1; Wt = 1; tick();
        Ra = 1; S = 1; Wac = 1; tick();
        check_ac(6, "seq_ac");
        expect_v(K_CARRY, 0, "seq_carry"); drain();
        Rac = 1; Wc = 1; tick();
        expect_v(K_C, 6, "seq_c"); expect_v(K_DONE, 0, "seq_done_pre"); drain();
        fin = 1; tick();
        expect_v(K_RES, 6, "seq_res"); expect_v(K_DONE, 1, "seq_done"); drain();
        tick();
        expect_v(K_DONE, 0, "seq_done_once"); drain();

        // fin with concurrent Wc captures the old C.
        Rb = 1; Wc = 1; fin = 1; tick();
        expect_v(K_RES, 6, "fin_old_c"); expect_v(K_C, 5, "fin_wc"); drain();

        // Add overflow.
        load_regs(200, 100, 0);
        Ra = 1; Wt = 1; tick();
        Rb = 1; S = 1; Wac = 1; tick();
        check_ac(ADD_OV, "add_ov_ac");
        expect_v(K_CARRY, 1, "add_ov_carry"); drain();

        // S=R=1 with Wac: AC and carry hold, error flagged.
        Rb = 1; S = 1; R = 1; Wac = 1; tick();
        check_ac(ADD_OV, "sr_ac_hold");
        expect_v(K_CARRY, 1, "sr_carry_hold"); expect_v(K_ERR, 1, "sr_err"); drain();
        load_regs(3, 5, 7);
        expect_v(K_ERR, 0, "sr_err_clr"); expect_v(K_CARRY, 0, "ld_carry_clr"); drain();
        check_ac(0, "ld_ac_clr");

        // Subtract borrow.
        Ra = 1; Wt = 1; tick();
        Rb = 1; R = 1; Wac = 1; tick();
        check_ac(SUB_UN, "sub_un_ac");
        expect_v(K_CARRY, 1, "sub_un_carry"); drain();
        Rb = 1; R = 1; Wac = 1; S = 0; tick();
        Ra = 1; S = 1; Wac = 1; tick();
        check_ac(6, "add_nc_ac");
        expect_v(K_CARRY, 0, "add_nc_carry"); drain();

        // Multi-read: bus 0, writes suppressed, sticky error.
        Ra = 1; Rb = 1; Wc = 1;
        #1;
        expect_v(K_BUS, 0, "mr_bus"); drain();
        tick();
        expect_v(K_C, 7, "mr_c_hold"); expect_v(K_ERR, 1, "mr_err"); drain();
        Ra = 1; Wb = 1; tick();
        expect_v(K_B, 3, "mr_after_wb"); expect_v(K_ERR, 1, "mr_err_sticky"); drain();

        // Self read/write plus multi-write of the same value.
        Ra = 1; Wa = 1; Wc = 1; tick();
        expect_v(K_A, 3, "self_rw_a"); expect_v(K_C, 3, "multi_w_c"); drain();
        load_regs(3, 5, 7);
        expect_v(K_ERR, 0, "mr_err_clr"); drain();

        // Reset mid-sequence together with fin.
        load_regs(9, 4, 1);
        Ra = 1; Wt = 1; tick();
        Rb = 1; Wac = 1; tick();
        check_ac(4, "pre_rst_ac");
        reset = 1; fin = 1; Rac = 1; Wc = 1; tick();
        expect_v(K_A, 0, "mid_rst_a"); expect_v(K_C, 0, "mid_rst_c");
        expect_v(K_RES, 0, "mid_rst_res"); expect_v(K_DONE, 0, "mid_rst_done");
        expect_v(K_CARRY, 0, "mid_rst_carry"); drain();
        check_ac(0, "mid_rst_ac");
        tick();
        expect_v(K_DONE, 0, "mid_rst_done2"); drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
